// File: rtl/pipelined_prefix_adder.sv
// Pipelined parallel-prefix adder: S = A + B + CIN with carry-out and signed overflow.
// Prefix topology picked by MODE (0 Kogge-Stone, 1 Brent-Kung, 2 Sklansky); a register
// cut follows every PIPE_EVERY prefix levels. Valid/ready on both sides, whole-pipe stall.
module pipelined_prefix_adder #(
  parameter int unsigned N          = 16,
  parameter int unsigned MODE       = 0,
  parameter int unsigned PIPE_EVERY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  input  logic         IN_VALID,
  output logic         IN_READY,
  output logic [N:0]   S,
  output logic         OVF,
  output logic         OUT_VALID,
  input  logic         OUT_READY
);

  localparam int unsigned LOG    = $clog2(N);
  localparam int unsigned LW     = (LOG < 1) ? 1 : LOG;
  localparam int unsigned LEVELS = (MODE == 1) ? 2 * LOG - 1 : LOG;
  localparam int unsigned PE     = (PIPE_EVERY == 0) ? 1 : PIPE_EVERY;
  localparam int unsigned K      = (LEVELS + PE - 1) / PE;

  if (!(N == 4 || N == 8 || N == 16 || N == 32 || N == 64)) begin : g_bad_n
    $error("pipelined_prefix_adder: N must be a power of two in 4..64");
  end
  if (PIPE_EVERY < 1 || PIPE_EVERY > LEVELS) begin : g_bad_pe
    $error("pipelined_prefix_adder: PIPE_EVERY must be in 1..LEVELS");
  end
  if (MODE > 2) begin : g_bad_mode
    $error("pipelined_prefix_adder: MODE must be 0, 1 or 2");
  end

  // Applies prefix levels lo..hi of the selected topology to (g,p); returns {g,p}.
  // Each level reads only the previous level's values, so nodes update independently.
  function automatic logic [2*N-1:0] prefix_levels(input logic [N-1:0] gi,
                                                   input logic [N-1:0] pi,
                                                   input int unsigned  lo,
                                                   input int unsigned  hi);
    logic [N-1:0]    g, p, og, op;
    logic [LW-1:0]   ii, j;
    int unsigned     d;
    logic            hit;
    g = gi;
    p = pi;
    for (int unsigned l = 1; l <= LEVELS; l++) begin
      if (l >= lo && l <= hi) begin
        og = g;
        op = p;
        for (int unsigned i = 0; i < N; i++) begin
          hit = 1'b0;
          j   = '0;
          ii  = LW'(i);
          case (MODE)
            1: begin
              if (l <= LOG) begin
                // up-sweep: combine blocks of size d into blocks of size 2d
                d = 32'd1 << (l - 1);
                if ((i + 1) % (2 * d) == 0) begin
                  hit = 1'b1;
                  j   = LW'(i - d);
                end
              end else begin
                // down-sweep: fill the middle nodes from the completed block below
                d = 32'd1 << (2 * LOG - l - 1);
                if (i >= 2 * d && (i + 1) % (2 * d) == d) begin
                  hit = 1'b1;
                  j   = LW'(i - d);
                end
              end
            end
            2: begin
              if (((i >> (l - 1)) & 32'd1) == 32'd1) begin
                hit = 1'b1;
                j   = LW'(((i >> (l - 1)) << (l - 1)) - 1);
              end
            end
            default: begin
              d = 32'd1 << (l - 1);
              if (i >= d) begin
                hit = 1'b1;
                j   = LW'(i - d);
              end
            end
          endcase
          if (hit) begin
            g[ii] = og[ii] | (op[ii] & og[j]);
            p[ii] = op[ii] & op[j];
          end
        end
      end
    end
    return {g, p};
  endfunction

  logic         advance;
  logic [K:0]   sv;
  logic [N-1:0] gw [0:K];
  logic [N-1:0] pw [0:K];
  logic [N-1:0] ow [0:K];
  logic         cw [0:K];

  logic [N-1:0] g0_q, p0_q;
  logic         c0_q;

  assign advance  = !OUT_VALID | OUT_READY;
  assign IN_READY = advance;

  assign gw[0] = g0_q;
  assign pw[0] = p0_q;
  assign ow[0] = p0_q;
  assign cw[0] = c0_q;

  // Valid bits of every stage advance together; bubbles travel as valid=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv        <= '0;
      OUT_VALID <= 1'b0;
    end else if (advance) begin
      sv        <= {sv[K-1:0], IN_VALID};
      OUT_VALID <= sv[K];
    end
  end

  // Stage 0: bitwise propagate/generate and carry-in.
  always_ff @(posedge clk) begin
    if (advance) begin
      g0_q <= A & B;
      p0_q <= A ^ B;
      c0_q <= CIN;
    end
  end

  for (genvar k = 1; k <= K; k++) begin : g_stage
    localparam int unsigned LO = (k - 1) * PE + 1;
    localparam int unsigned HI = (k * PE < LEVELS) ? k * PE : LEVELS;

    logic [N-1:0]   gin;
    logic [2*N-1:0] gp;
    logic [N-1:0]   g_q, p_q, o_q;
    logic           c_q;

    if (k == 1) begin : g_fold
      // carry-in acts as a generate just below bit 0, so it is absorbed into g[0]
      assign gin = {gw[0][N-1:1], gw[0][0] | (pw[0][0] & cw[0])};
    end else begin : g_pass
      assign gin = gw[k-1];
    end

    assign gp = prefix_levels(gin, pw[k-1], LO, HI);

    // Register the group prefix after this stage's slice of levels.
    always_ff @(posedge clk) begin
      if (advance) begin
        g_q <= gp[2*N-1:N];
        p_q <= gp[N-1:0];
        o_q <= ow[k-1];
        c_q <= cw[k-1];
      end
    end

    assign gw[k] = g_q;
    assign pw[k] = p_q;
    assign ow[k] = o_q;
    assign cw[k] = c_q;
  end

  // c[0] = CIN, c[i] = group generate of bits i-1..0 (carry-in included).
  logic [N:0] c;
  assign c = {gw[K], cw[K]};

  // Output stage: sum, carry-out and signed overflow; only loaded with valid data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S   <= '0;
      OVF <= 1'b0;
    end else if (advance && sv[K]) begin
      S   <= {c[N], ow[K] ^ c[N-1:0]};
      OVF <= c[N] ^ c[N-1];
    end
  end

endmodule
